// File: rtl/level_sensor_pkg.sv
// Shared types and constants for the float-sensor front-end.
// Health states, legal thermometer levels and the legality check.
package level_sensor_pkg;

  typedef enum logic [1:0] {
    OK      = 2'd0,
    SUSPECT = 2'd1,
    FAULT   = 2'd2,
    RECOVER = 2'd3
  } health_e;

  localparam logic [2:0] LVL_EMPTY = 3'b000;
  localparam logic [2:0] LVL_LOW   = 3'b001;
  localparam logic [2:0] LVL_MID   = 3'b011;
  localparam logic [2:0] LVL_HIGH  = 3'b111;

  function automatic logic is_legal_level(input logic [2:0] lvl);
    return (lvl == LVL_EMPTY) || (lvl == LVL_LOW) ||
           (lvl == LVL_MID)   || (lvl == LVL_HIGH);
  endfunction

endpackage

// File: rtl/level_sensor_conditioner_debounce.sv
// Per-bit two-flop synchronizer followed by a run-length debouncer.
// The stable bit flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
module sensor_bit_debounce
  import level_sensor_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic stable_o
);

  localparam logic [7:0] LIMIT = 8'(DEBOUNCE_CYCLES);

  logic       sync1_q;
  logic       sync2_q;
  logic       stable_q;
  logic [7:0] cnt_q;

  // Synchronize, then count disagreement and flip on reaching the limit.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= 8'd0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      if (sync2_q == stable_q) begin
        cnt_q <= 8'd0;
      end else if (cnt_q == LIMIT - 8'd1) begin
        stable_q <= ~stable_q;
        cnt_q    <= 8'd0;
      end else begin
        cnt_q <= cnt_q + 8'd1;
      end
    end
  end

  assign stable_o = stable_q;

endmodule

// File: rtl/level_sensor_conditioner.sv
// Sensor front-end: debounce, legality check, health FSM, clean s bus.
// Optional fault-entry counter built only with LEVEL_SENSOR_FAULT_CNT_EN.
module level_sensor_conditioner
  import level_sensor_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 8,
  parameter int unsigned FAULT_CYCLES    = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] raw_s,
  output logic [2:0] s,
  output logic       s_chg,
  output logic       fault,
  output logic [7:0] fault_count
);

  localparam logic [7:0] FLIM = 8'(FAULT_CYCLES);

  logic [2:0] d;

  for (genvar i = 0; i < 3; i++) begin : g_bit
    sensor_bit_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk     (clk),
      .reset   (reset),
      .raw_i   (raw_s[i]),
      .stable_o(d[i])
    );
  end

  health_e    state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  // s_q doubles as the last legal level: it only ever loads a legal d.
  logic [2:0] s_q, s_d;
  logic       s_chg_q;
  logic       fault_q, fault_d;
  logic       legal;

  // Next-state logic of the health FSM and the held level.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    legal   = is_legal_level(d);
    unique case (state_q)
      OK: begin
        if (legal) begin
          s_d = d;
        end else begin
          state_d = SUSPECT;
          cnt_d   = 8'd1;
        end
      end
      SUSPECT: begin
        if (legal) begin
          state_d = OK;
          cnt_d   = 8'd0;
          s_d     = d;
        end else if (cnt_q + 8'd1 == FLIM) begin
          state_d = FAULT;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      FAULT: begin
        if (legal) begin
          state_d = RECOVER;
          cnt_d   = 8'd1;
        end
      end
      RECOVER: begin
        if (!legal) begin
          state_d = FAULT;
          cnt_d   = 8'd0;
        end else if (cnt_q + 8'd1 == FLIM) begin
          state_d = OK;
          cnt_d   = 8'd0;
          s_d     = d;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = OK;
        cnt_d   = 8'd0;
      end
    endcase
    // Rises one cycle after FAULT entry, falls on the edge back to OK.
    fault_d = ((state_q == FAULT) || (state_q == RECOVER)) &&
              (state_d != OK);
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= OK;
      cnt_q   <= 8'd0;
      s_q     <= LVL_EMPTY;
      s_chg_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      s_chg_q <= (s_d != s_q);
      fault_q <= fault_d;
    end
  end

  assign s     = s_q;
  assign s_chg = s_chg_q;
  assign fault = fault_q;

`ifdef LEVEL_SENSOR_FAULT_CNT_EN
  logic       enter_fault;
  logic [7:0] fcnt_q;

  assign enter_fault = (state_d == FAULT) && (state_q != FAULT);

  // Saturating count of FAULT entries, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      fcnt_q <= 8'd0;
    end else if (enter_fault && (fcnt_q != 8'hFF)) begin
      fcnt_q <= fcnt_q + 8'd1;
    end
  end

  assign fault_count = fcnt_q;
`else
  assign fault_count = 8'd0;
`endif

endmodule

// File: tb/tb_level_sensor_conditioner.sv
// Bench for level_sensor_conditioner: directed sequences, a vector
// table and random stimulus against a run-length reference model.
module tb_level_sensor_conditioner;

  localparam int DC = 8;
  localparam int FC = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] raw_s = 3'b000;
  logic [2:0] s;
  logic       s_chg;
  logic       fault;
  logic [7:0] fault_count;

  level_sensor_conditioner #(
    .DEBOUNCE_CYCLES(DC),
    .FAULT_CYCLES(FC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .raw_s      (raw_s),
    .s          (s),
    .s_chg      (s_chg),
    .fault      (fault),
    .fault_count(fault_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference model: sync pipeline as sample delays, debounce as
  // "last DC synchronized samples all disagree", health as run lengths.
  logic [2:0]   m_p1 = 0, m_p2 = 0, m_stab = 0;
  logic [255:0] m_hist [3];
  logic [2:0]   m_s = 0;
  bit           m_faulted = 0, m_fault = 0, m_chg = 0;
  int           m_bad = 0, m_good = 0, m_entries = 0;
  bit           mdl_on = 0;

  initial for (int b = 0; b < 3; b++) m_hist[b] = '0;

  function automatic bit lvl_ok(input logic [2:0] v);
    return v == 3'b000 || v == 3'b001 || v == 3'b011 || v == 3'b111;
  endfunction

  always @(posedge clk) begin
    logic [2:0] dv, s_old;
    bit was, all_diff;
    if (reset) begin
      m_p1 = 0; m_p2 = 0; m_stab = 0; m_s = 0;
      m_faulted = 0; m_fault = 0; m_chg = 0;
      m_bad = 0; m_good = 0; m_entries = 0;
      for (int b = 0; b < 3; b++) m_hist[b] = '0;
    end else begin
      dv = m_stab;
      was = m_faulted;
      s_old = m_s;
      if (!m_faulted) begin
        if (lvl_ok(dv)) begin
          m_s = dv;
          m_bad = 0;
        end else begin
          m_bad++;
          if (m_bad == FC) begin
            m_faulted = 1; m_entries++; m_bad = 0; m_good = 0;
          end
        end
      end else begin
        if (lvl_ok(dv)) begin
          m_good++;
          if (m_good == FC) begin
            m_faulted = 0; m_s = dv; m_good = 0;
          end
        end else begin
          if (m_good > 0) m_entries++;
          m_good = 0;
        end
      end
      m_fault = was && m_faulted;
      m_chg = (m_s != s_old);
      for (int b = 0; b < 3; b++) begin
        m_hist[b] = {m_hist[b][254:0], m_p2[b]};
        all_diff = 1;
        for (int k = 0; k < DC; k++)
          if (m_hist[b][k] == m_stab[b]) all_diff = 0;
        if (all_diff) begin
          m_stab[b] = ~m_stab[b];
          m_hist[b] = {256{m_stab[b]}};
        end
      end
      m_p2 = m_p1;
      m_p1 = raw_s;
    end
  end

  function automatic logic [7:0] m_fc();
`ifdef LEVEL_SENSOR_FAULT_CNT_EN
    return (m_entries > 255) ? 8'd255 : 8'(m_entries);
`else
    return 8'd0;
`endif
  endfunction

  always @(negedge clk) begin
    if (mdl_on) begin
      chk("mdl_s", 32'(s), 32'(m_s));
      chk("mdl_s_chg", 32'(s_chg), 32'(m_chg));
      chk("mdl_fault", 32'(fault), 32'(m_fault));
      chk("mdl_fcount", 32'(fault_count), 32'(m_fc()));
    end
  end

  typedef struct {
    logic [2:0] raw;
    int         hold;
    logic [2:0] s;
    logic       f;
  } vec_t;

  vec_t tbl [12];

  task automatic hold(input logic [2:0] v, input int n);
    raw_s = v;
    repeat (n) cyc();
  endtask

  initial begin
    int pulses;
    bit saw;

    tbl[0]  = '{3'b000, 20, 3'b000, 1'b0};
    tbl[1]  = '{3'b001, 20, 3'b001, 1'b0};
    tbl[2]  = '{3'b011, 20, 3'b011, 1'b0};
    tbl[3]  = '{3'b111, 20, 3'b111, 1'b0};
    tbl[4]  = '{3'b110, 40, 3'b111, 1'b1};
    tbl[5]  = '{3'b111, 40, 3'b111, 1'b0};
    tbl[6]  = '{3'b001, 20, 3'b001, 1'b0};
    tbl[7]  = '{3'b000, 20, 3'b000, 1'b0};
    tbl[8]  = '{3'b010, 15, 3'b000, 1'b0};
    tbl[9]  = '{3'b000, 30, 3'b000, 1'b0};
    tbl[10] = '{3'b010, 16, 3'b000, 1'b0};
    tbl[11] = '{3'b000, 12, 3'b000, 1'b1};

    // Reset state, every reset cycle.
    reset = 1;
    raw_s = 3'b000;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("rst_s", 32'(s), 0);
      chk("rst_fault", 32'(fault), 0);
      chk("rst_s_chg", 32'(s_chg), 0);
      chk("rst_fcount", 32'(fault_count), 0);
    end
    mdl_on = 1;
    reset = 0;
    hold(3'b000, 4);
    chk("post_rst_s", 32'(s), 0);

    // Latency: s changes on edge DC+3 after the first sampling edge.
    raw_s = 3'b001;
    for (int k = 1; k <= 12; k++) begin
      cyc();
      if (k == 10) chk("lat1_before", 32'(s), 32'h0);
      if (k == 11) begin
        chk("lat1_s", 32'(s), 32'h1);
        chk("lat1_chg", 32'(s_chg), 1);
      end
      if (k == 12) chk("lat1_chg_off", 32'(s_chg), 0);
    end
    hold(3'b001, 5);
    raw_s = 3'b011;
    for (int k = 1; k <= 11; k++) begin
      cyc();
      if (k == 10) chk("lat2_before", 32'(s), 32'h1);
      if (k == 11) chk("lat2_s", 32'(s), 32'h3);
    end
    hold(3'b011, 10);

    // Glitch of DC-1 cycles is filtered.
    hold(3'b111, DC - 1);
    pulses = 0;
    saw = 0;
    raw_s = 3'b011;
    for (int k = 0; k < 25; k++) begin
      cyc();
      if (s_chg) pulses++;
      if (s != 3'b011) saw = 1;
    end
    chk("glitch7_chg", 32'(pulses), 0);
    chk("glitch7_s", 32'(saw), 0);

    // Glitch of exactly DC cycles passes.
    hold(3'b111, DC);
    saw = 0;
    raw_s = 3'b011;
    for (int k = 0; k < 25; k++) begin
      cyc();
      if (s == 3'b111) saw = 1;
    end
    chk("glitch8_seen", 32'(saw), 1);
    chk("glitch8_back", 32'(s), 32'h3);

    // Illegal 101 from 001: s held, FAULT then recovery to 111.
    hold(3'b001, 30);
    chk("pre_fault_s", 32'(s), 32'h1);
    hold(3'b101, 40);
    chk("fault_hold_s", 32'(s), 32'h1);
    chk("fault_up", 32'(fault), 1);
    pulses = 0;
    raw_s = 3'b111;
    for (int k = 0; k < 40; k++) begin
      cyc();
      if (s_chg) pulses++;
    end
    chk("recov_fault", 32'(fault), 0);
    chk("recov_s", 32'(s), 32'h7);
    chk("recov_pulses", 32'(pulses), 1);

    // Short illegal burst: no fault.
    hold(3'b010, 10);
    hold(3'b011, 30);
    chk("burst_s", 32'(s), 32'h3);
    chk("burst_fault", 32'(fault), 0);

    // Reset in RECOVER with its counter at 9.
    hold(3'b101, 40);
    chk("pre_rec_fault", 32'(fault), 1);
    hold(3'b111, 19);
    chk("rec9_fault", 32'(fault), 1);
    chk("rec9_s", 32'(s), 32'h3);
    reset = 1;
    raw_s = 3'b000;
    cyc();
    reset = 0;
    chk("midrst_s", 32'(s), 0);
    chk("midrst_fault", 32'(fault), 0);
    chk("midrst_fcount", 32'(fault_count), 0);
    chk("midrst_chg", 32'(s_chg), 0);
    cyc();
    chk("midrst_s1", 32'(s), 0);
    chk("midrst_f1", 32'(fault), 0);
    hold(3'b000, 5);

    // Vector table.
    for (int i = 0; i < 12; i++) begin
      hold(tbl[i].raw, tbl[i].hold);
      chk($sformatf("tbl%0d_s", i), 32'(s), 32'(tbl[i].s));
      chk($sformatf("tbl%0d_f", i), 32'(fault), 32'(tbl[i].f));
    end

    // Random stimulus, biased toward legal levels, occasional reset.
    for (int i = 0; i < 120; i++) begin
      logic [2:0] v;
      if ($urandom_range(0, 9) < 7) begin
        case ($urandom_range(0, 3))
          0: v = 3'b000;
          1: v = 3'b001;
          2: v = 3'b011;
          default: v = 3'b111;
        endcase
      end else begin
        v = 3'($urandom_range(0, 7));
      end
      if ($urandom_range(0, 49) == 0) begin
        reset = 1;
        cyc();
        reset = 0;
      end
      hold(v, $urandom_range(1, 40));
    end

`ifdef LEVEL_SENSOR_FAULT_CNT_EN
    reset = 1;
    raw_s = 3'b000;
    cyc();
    reset = 0;
    hold(3'b101, 40);
    for (int i = 0; i < 300; i++) begin
      hold(3'b111, 12);
      hold(3'b101, 12);
    end
    chk("fcount_sat", 32'(fault_count), 32'd255);
`endif

    mdl_on = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/level_sensor_conditioner.md
Name: level_sensor_conditioner

Overview:
- Upstream front-end for the reservoir flow-rate controller FSM.
- Synchronizes and debounces the three raw float-sensor lines.
- Checks that the debounced vector is a legal thermometer code and drives the clean s[2:0] bus the controller consumes.
- Detects persistent sensor faults, flags them, and holds the last legal level so the controller never sees an illegal pattern.

Parameters:
- DEBOUNCE_CYCLES, 8: consecutive cycles a synchronized bit must differ from its stable value before the stable value flips; legal range 2..255.
- FAULT_CYCLES, 16: consecutive cycles an illegal or legal pattern must persist to enter or leave FAULT; legal range 2..255.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- raw_s  in  3  asynchronous float-sensor inputs; bit0 is the lowest sensor
- s  out  3  conditioned level to the flow controller; always one of 000/001/011/111
- s_chg  out  1  one-cycle pulse in the cycle s takes a new value
- fault  out  1  high while the sensor-health FSM is in FAULT or RECOVER
- fault_count  out  8  saturating count of FAULT entries (see Optional Feature)

Behaviour:
- Reset values:
  - Synchronizer flops, stable bits and all counters: 0.
  - FSM: OK.
  - Outputs: s=000, last_legal=000, s_chg=0, fault=0, fault_count=0.
- Synchronizer: two flops per bit.
- Debounce, per bit:
  - The counter clears whenever the synchronized bit equals the stable bit.
  - Otherwise the counter increments.
  - When it reaches DEBOUNCE_CYCLES, the stable bit flips and the counter clears in the same edge.
- Latency: a clean raw change first sampled at edge 1 gives a stable-bit flip at edge DEBOUNCE_CYCLES+2 and an s update at edge DEBOUNCE_CYCLES+3 (11 with defaults).
- A glitch shorter than DEBOUNCE_CYCLES cycles at the synchronizer output never reaches s.
- Legality: the debounced vector d is legal iff d is 000, 001, 011 or 111.
- Health FSM, states OK, SUSPECT, FAULT, RECOVER; one shared cycle counter, cleared on every state change:
  - OK: d legal -> stay in OK, and s<=d, last_legal<=d. d illegal -> SUSPECT, counter=1.
  - SUSPECT: d legal -> OK, and s<=d in that same edge. d illegal -> counter++; at counter==FAULT_CYCLES -> FAULT.
  - FAULT: d illegal -> stay. d legal -> RECOVER, counter=1.
  - RECOVER: d illegal -> FAULT. d legal -> counter++; at counter==FAULT_CYCLES -> OK, and s<=d in that edge.
- s holds last_legal in SUSPECT, FAULT and RECOVER.
- fault=1 is registered and asserts in the cycle after the FSM enters FAULT.
- fault stays high through RECOVER and deasserts in the cycle the FSM returns to OK.
- s_chg: registered, equal to (s_next != s). It is never asserted in the reset cycle.
- Reset mid-operation (any state, any counter value): every register returns to its reset value on that edge. The first post-reset cycle behaves as after power-up.
- Counter widths: 8 bits. No wrap is possible within the legal parameter range.

Optional Feature:
- Macro: LEVEL_SENSOR_FAULT_CNT_EN.
- Defined:
  - fault_count increments by 1 on each transition into FAULT, from SUSPECT or from RECOVER.
  - It saturates at 255 and is cleared only by reset.
- Undefined: the fault_count port still exists, is tied to 0, and no counter flops are built.

Decomposition:
- Package level_sensor_pkg holds:
  - the health-state enum (OK, SUSPECT, FAULT, RECOVER);
  - the legal-pattern constants LVL_EMPTY=000, LVL_LOW=001, LVL_MID=011, LVL_HIGH=111;
  - a function is_legal_level(logic [2:0]).
- One sub-module, sensor_bit_debounce, instantiated 3x: synchronizer plus debounce counter, parameterized by DEBOUNCE_CYCLES, output is the stable bit.

Test Plan (defaults 8/16):
- Reset, raw_s=000 -> s=000, fault=0, s_chg=0, fault_count=0 on every cycle of reset and after it.
- raw_s 000->001, held -> s=001 at edge 11 after the first sampling edge; s_chg high for exactly that one cycle. Then raw_s->011, held -> s=011 after another 11 edges.
- Glitch: raw_s=011 steady, bit2 pulsed to 1 for 7 cycles -> s stays 011 and s_chg never pulses. Repeat with an 8-cycle pulse at the synchronizer -> s becomes 111.
- raw_s=101 held (illegal) from s=001 -> s holds 001, FSM is in FAULT after 16 illegal cycles, fault=1 the cycle after. Then raw_s=111 held -> fault drops after 16 legal cycles and s=111 with one s_chg pulse.
- Illegal 010 for 10 cycles, then legal 011 -> no fault, FSM returns to OK, s=011. With LEVEL_SENSOR_FAULT_CNT_EN: 300 forced fault entries -> fault_count=255.
- Reset asserted while in RECOVER with counter=9 -> next cycle: state OK, s=000, fault=0, fault_count=0.
